irq_controller: RTL



---
 rtl/irq_controller.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-latched, masked, fixed-priority interrupt entry controller (optional IRQ_SYNC_EN)
module irq_controller #(
    parameter int          N_SRC      = 4,
    parameter int          ID_W       = 2,
    parameter logic [10:0] VEC_BASE   = 11'h7C0,
    parameter int          VEC_STRIDE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [N_SRC-1:0] irq_mask,
    input  logic             global_en,
    input  logic [10:0]      rom_pc,
    input  logic             take_allow,
    input  logic             pc_stack_full,
    input  logic             interrupt_clear_status,
    output logic             irq_inject,
    output logic             irq_push_enable,
    output logic [10:0]      irq_push_data,
    output logic             irq_jump_enable,
    output logic [10:0]      irq_jump_data,
    output logic             irq_active,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] irq_pending
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [10:0] STRIDE11 = 11'(VEC_STRIDE);

    logic [N_SRC-1:0] src_s;

`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync1_d;
    logic [N_SRC-1:0] sync2_q, sync2_d;

    // Two-flop synchronizer input stage; ones at reset so high lines look idle
    always_comb begin
        sync1_d = irq_src;
        sync2_d = sync1_q;
    end

    // Synchronizer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = irq_src;
`endif

    logic [N_SRC-1:0] src_q, src_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [ID_W-1:0]  id_q, id_d;
    state_t           state_q, state_d;

    logic [N_SRC-1:0] edge_det;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] clr_bit;
    logic [ID_W-1:0]  winner;
    logic [10:0]      id_ext;
    logic             fire;

    // Edge detect, eligibility, lowest-index priority pick and next pending state
    always_comb begin
        src_d    = src_s;
        edge_det = src_s & ~src_q;
        eligible = pending_q & irq_mask & {N_SRC{global_en}};
        winner   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = ID_W'(i);
            end
        end
        clr_bit = '0;
        if (fire) begin
            clr_bit[id_q] = 1'b1;
        end
        // A new edge on the bit being taken keeps it pending for a later re-entry
        pending_d = (pending_q & ~clr_bit) | edge_det;
    end

    // Entry FSM: next state, latched id and combinational entry outputs
    always_comb begin
        state_d         = state_q;
        id_d            = id_q;
        fire            = 1'b0;
        id_ext          = 11'(id_q);
        irq_inject      = 1'b0;
        irq_push_enable = 1'b0;
        irq_push_data   = '0;
        irq_jump_enable = 1'b0;
        irq_jump_data   = '0;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    id_d    = winner;
                    state_d = ST_TAKE;
                end
            end
            ST_TAKE: begin
                if (!eligible[id_q]) begin
                    state_d = ST_IDLE;
                end else if (take_allow && !pc_stack_full) begin
                    fire            = 1'b1;
                    irq_inject      = 1'b1;
                    irq_push_enable = 1'b1;
                    irq_push_data   = rom_pc;
                    irq_jump_enable = 1'b1;
                    irq_jump_data   = VEC_BASE + id_ext * STRIDE11;
                    state_d         = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (interrupt_clear_status) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; previous-sample register resets to ones to suppress reset-time edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q     <= '1;
            pending_q <= '0;
            id_q      <= '0;
            state_q   <= ST_IDLE;
        end else begin
            src_q     <= src_d;
            pending_q <= pending_d;
            id_q      <= id_d;
            state_q   <= state_d;
        end
    end

    assign irq_active  = (state_q == ST_SERVICE);
    assign irq_id      = id_q;
    assign irq_pending = pending_q;

endmodule
